hazard_unit: RTL and testbench
==============================

# hazard_unit

Pipeline hazard controller for the five-stage (F/D/E/M/W) Filter-GPU core. It resolves data hazards with combinational forwarding mux selects for both execute-stage operands. It resolves load-use hazards by stalling Fetch/Decode and flushing Execute, and resolves control hazards by flushing on PC writes and taken branches. A small clocked block keeps saturating stall/flush event counters for performance debug.

## Interface
Parameters:
- CNT_W, 16, width of the stall and flush event counters

Ports (name, direction, width, meaning):
- clk  in  1  core clock; the only clock
- rst_n  in  1  asynchronous, active-low reset
- RA1E  in  4  source register 1 of the instruction in Execute
- RA2E  in  4  source register 2 of the instruction in Execute
- WA3M  in  4  destination register in Memory
- WA3W  in  4  destination register in Writeback
- RegWriteM  in  1  Memory-stage instruction writes the register file
- RegWriteW  in  1  Writeback-stage instruction writes the register file
- ForwardAE  out  2  operand A select: 00 register file, 01 ResultW, 10 ALUResultM
- ForwardBE  out  2  operand B select, same encoding as ForwardAE
- RA1D  in  4  source register 1 in Decode
- RA2D  in  4  source register 2 in Decode
- WA3E  in  4  destination register in Execute
- MemtoRegE  in  1  Execute-stage instruction is a load
- PCWrPendingF  in  1  a PC write (R15 destination) is in flight in D, E or M
- PCSrcW  in  1  Writeback is writing the PC
- BranchTakenE  in  1  branch resolved taken in Execute
- StallF  out  1  hold the PC register
- StallD  out  1  hold the F/D pipeline register
- FlushD  out  1  clear the F/D register to a bubble
- FlushE  out  1  clear the D/E register to a bubble
- StallCount  out  CNT_W  saturating count of cycles with StallD high
- FlushCount  out  CNT_W  saturating count of cycles with FlushE high

## Operation
- Forwarding, evaluated independently for A (RA1E) and B (RA2E):
  - Match1M = RegWriteM and (RAxE == WA3M).
  - Match1W = RegWriteW and (RAxE == WA3W).
  - If Match1M, the select is 10. Otherwise, if Match1W, the select is 01. Otherwise it is 00.
  - Memory has priority over Writeback when both match.
  - All 16 register indices are eligible, including R0 and R15; there is no special zero register.
  - An X or Z on RegWriteW counts as not-writing (use explicit === 1'b1 comparisons, or equivalent).
- Load-use stall:
  - ldrStallD = MemtoRegE and ((RA1D == WA3E) or (RA2D == WA3E)).
- Control outputs:
  - StallF = ldrStallD or PCWrPendingF.
  - StallD = ldrStallD.
  - FlushD = PCWrPendingF or PCSrcW or BranchTakenE.
  - FlushE = ldrStallD or BranchTakenE.
- Counters:
  - On each rising clk edge, StallCount increments if StallD is high, and FlushCount increments if FlushE is high.
  - Each counter saturates at all-ones and never wraps.

## Timing
- Forwarding, stall and flush outputs are purely combinational, with zero-cycle latency. They are valid in the same cycle as their inputs and are not affected by reset.
- Counters are registered and update one cycle after the qualifying condition.
- While rst_n is low, both counters are forced to 0 asynchronously. They resume counting on the first rising edge after rst_n deasserts.
- Simultaneous events:
  - ldrStallD and BranchTakenE both high: FlushE stays 1, StallF/StallD stay 1, FlushD stays 1. The flush wins downstream and the D stall is harmless.
  - FlushE high and StallD high in the same cycle increments both counters.

## Structure
- A shared package holds the forwarding encoding constants FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10 and the register index type logic [3:0].
- One sub-module is natural: forward_sel, instantiated twice. It takes RAxE, WA3M, WA3W, RegWriteM and RegWriteW, and outputs a 2-bit select.
- Stall/flush logic and the counters live in the top module.

## Test plan
- Forward from M: RA1E=RA2E=WA3M=WA3W=0, RegWriteM=1, RegWriteW=X -> ForwardAE=ForwardBE=10. Repeat for 5 consecutive 15 ns steps; the outputs stay stable.
- Priority and W path:
  - RA1E=3, RA2E=5, WA3M=3, WA3W=5, both RegWrite=1 -> ForwardAE=10, ForwardBE=01.
  - RegWriteM=0 with WA3M=WA3W=3 -> ForwardAE=01.
  - No match -> 00.
- Load-use stall: MemtoRegE=1, WA3E=7, RA2D=7 -> StallF=StallD=FlushE=1, FlushD=0. With MemtoRegE=0 -> all four are 0.
- Control hazards:
  - BranchTakenE=1 -> FlushD=FlushE=1, StallF=0.
  - PCWrPendingF=1 -> StallF=FlushD=1, StallD=0.
  - PCSrcW=1 alone -> FlushD=1 only.
- Counters:
  - Hold ldrStallD for 4 cycles -> StallCount=4, FlushCount=4.
  - Assert rst_n=0 mid-count -> both 0 immediately, without waiting for a clock edge.
  - Preload near max (CNT_W=4) -> the counter sticks at 15.

Source files
------------

// File: rtl/hazard_unit_pkg.sv
// Shared types and forwarding-select encodings for the pipeline hazard controller.
package hazard_unit_pkg;

    typedef logic [3:0] reg_idx_t;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

endpackage

// File: rtl/hazard_unit_forward_sel.sv
// Execute-stage operand forwarding select; Memory result takes priority over Writeback.
module forward_sel
    import hazard_unit_pkg::*;
(
    input  reg_idx_t   ra_e,
    input  reg_idx_t   wa3_m,
    input  reg_idx_t   wa3_w,
    input  logic       reg_write_m,
    input  logic       reg_write_w,
    output logic [1:0] sel
);

    logic match_m;
    logic match_w;

    // Unknown write enables are treated as not-writing.
    assign match_m = (reg_write_m === 1'b1) && (ra_e == wa3_m);
    assign match_w = (reg_write_w === 1'b1) && (ra_e == wa3_w);

    always_comb begin
        sel = FWD_RF;
        if (match_m) begin
            sel = FWD_MEM;
        end else if (match_w) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: operand forwarding, load-use stall, control flush,
// and saturating stall/flush event counters for performance debug.
module hazard_unit
    import hazard_unit_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       RA1E,
    input  logic [3:0]       RA2E,
    input  logic [3:0]       WA3M,
    input  logic [3:0]       WA3W,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    input  logic [3:0]       RA1D,
    input  logic [3:0]       RA2D,
    input  logic [3:0]       WA3E,
    input  logic             MemtoRegE,
    input  logic             PCWrPendingF,
    input  logic             PCSrcW,
    input  logic             BranchTakenE,
    output logic             StallF,
    output logic             StallD,
    output logic             FlushD,
    output logic             FlushE,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic ldr_stall;

    forward_sel u_fwd_a (
        .ra_e        (RA1E),
        .wa3_m       (WA3M),
        .wa3_w       (WA3W),
        .reg_write_m (RegWriteM),
        .reg_write_w (RegWriteW),
        .sel         (ForwardAE)
    );

    forward_sel u_fwd_b (
        .ra_e        (RA2E),
        .wa3_m       (WA3M),
        .wa3_w       (WA3W),
        .reg_write_m (RegWriteM),
        .reg_write_w (RegWriteW),
        .sel         (ForwardBE)
    );

    always_comb begin
        ldr_stall = MemtoRegE && ((RA1D == WA3E) || (RA2D == WA3E));
        StallF    = ldr_stall || PCWrPendingF;
        StallD    = ldr_stall;
        FlushD    = PCWrPendingF || PCSrcW || BranchTakenE;
        FlushE    = ldr_stall || BranchTakenE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            StallCount <= '0;
            FlushCount <= '0;
        end else begin
            if (StallD && (StallCount != '1)) begin
                StallCount <= StallCount + CNT_ONE;
            end
            if (FlushE && (FlushCount != '1)) begin
                FlushCount <= FlushCount + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed self-checking bench for hazard_unit (default and 4-bit counter widths).
module tb_hazard_unit;

    logic       clk;
    logic       rst_n;
    logic [3:0] RA1E, RA2E, WA3M, WA3W;
    logic       RegWriteM, RegWriteW;
    logic [3:0] RA1D, RA2D, WA3E;
    logic       MemtoRegE, PCWrPendingF, PCSrcW, BranchTakenE;

    logic [1:0]  ForwardAE, ForwardBE, ForwardAE_s, ForwardBE_s;
    logic        StallF, StallD, FlushD, FlushE;
    logic        StallF_s, StallD_s, FlushD_s, FlushE_s;
    logic [15:0] StallCount, FlushCount;
    logic [3:0]  StallCount_s, FlushCount_s;

    int checks   = 0;
    int failures = 0;

    hazard_unit #(.CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .RA1E(RA1E), .RA2E(RA2E), .WA3M(WA3M), .WA3W(WA3W),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .RA1D(RA1D), .RA2D(RA2D), .WA3E(WA3E), .MemtoRegE(MemtoRegE),
        .PCWrPendingF(PCWrPendingF), .PCSrcW(PCSrcW), .BranchTakenE(BranchTakenE),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
        .StallCount(StallCount), .FlushCount(FlushCount)
    );

    hazard_unit #(.CNT_W(4)) dut_small (
        .clk(clk), .rst_n(rst_n),
        .RA1E(RA1E), .RA2E(RA2E), .WA3M(WA3M), .WA3W(WA3W),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .ForwardAE(ForwardAE_s), .ForwardBE(ForwardBE_s),
        .RA1D(RA1D), .RA2D(RA2D), .WA3E(WA3E), .MemtoRegE(MemtoRegE),
        .PCWrPendingF(PCWrPendingF), .PCSrcW(PCSrcW), .BranchTakenE(BranchTakenE),
        .StallF(StallF_s), .StallD(StallD_s), .FlushD(FlushD_s), .FlushE(FlushE_s),
        .StallCount(StallCount_s), .FlushCount(FlushCount_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Control outputs packed as {StallF, StallD, FlushD, FlushE}
    function automatic logic [31:0] ctl();
        return {28'd0, StallF, StallD, FlushD, FlushE};
    endfunction

    initial begin
        rst_n = 1'b0;
        RA1E = '0; RA2E = '0; WA3M = '0; WA3W = '0;
        RegWriteM = 1'b0; RegWriteW = 1'b0;
        RA1D = '0; RA2D = '0; WA3E = '0;
        MemtoRegE = 1'b0; PCWrPendingF = 1'b0; PCSrcW = 1'b0; BranchTakenE = 1'b0;

        #2;
        check("reset_stall_cnt", StallCount, 0);
        check("reset_flush_cnt", FlushCount, 0);
        check("idle_fwd_a", ForwardAE, 2'b00);
        check("idle_ctl", ctl(), 4'b0000);

        // Forward from M with unknown W write enable, held over several steps
        RegWriteM = 1'b1; RegWriteW = 1'bx;
        for (int i = 0; i < 5; i++) begin
            #15;
            check("fwd_m_a", ForwardAE, 2'b10);
            check("fwd_m_b", ForwardBE, 2'b10);
        end

        RA1E = 4'd3; RA2E = 4'd5; WA3M = 4'd3; WA3W = 4'd5;
        RegWriteM = 1'b1; RegWriteW = 1'b1;
        #1;
        check("prio_a_mem", ForwardAE, 2'b10);
        check("prio_b_wb", ForwardBE, 2'b01);

        RegWriteM = 1'b0; WA3M = 4'd3; WA3W = 4'd3;
        #1;
        check("wb_only_a", ForwardAE, 2'b01);
        check("wb_only_b", ForwardBE, 2'b00);

        RegWriteM = 1'b1; WA3M = 4'd3; WA3W = 4'd3;
        #1;
        check("both_same_a", ForwardAE, 2'b10);

        RA1E = 4'd15; RA2E = 4'd15; WA3M = 4'd15; RegWriteM = 1'b0; WA3W = 4'd15;
        #1;
        check("r15_wb_a", ForwardAE, 2'b01);

        RA1E = 4'd1; RA2E = 4'd2; WA3M = 4'd4; WA3W = 4'd6; RegWriteM = 1'b1;
        #1;
        check("nomatch_a", ForwardAE, 2'b00);
        check("nomatch_b", ForwardBE, 2'b00);
        RegWriteM = 1'b0; RegWriteW = 1'b0;

        MemtoRegE = 1'b1; WA3E = 4'd7; RA1D = 4'd2; RA2D = 4'd7;
        #1;
        check("ldr_use_rb", ctl(), 4'b1101);
        RA1D = 4'd7; RA2D = 4'd1;
        #1;
        check("ldr_use_ra", ctl(), 4'b1101);
        MemtoRegE = 1'b0;
        #1;
        check("no_load", ctl(), 4'b0000);

        BranchTakenE = 1'b1;
        #1;
        check("branch", ctl(), 4'b0011);
        MemtoRegE = 1'b1;
        #1;
        check("branch_and_ldr", ctl(), 4'b1111);
        MemtoRegE = 1'b0; BranchTakenE = 1'b0;

        PCWrPendingF = 1'b1;
        #1;
        check("pc_wr_pending", ctl(), 4'b1010);
        PCWrPendingF = 1'b0; PCSrcW = 1'b1;
        #1;
        check("pc_src_w", ctl(), 4'b0010);
        PCSrcW = 1'b0;
        #1;
        check("held_in_reset_cnt", StallCount, 0);

        // Counters: release reset and hold a load-use stall for 4 edges
        @(negedge clk);
        rst_n = 1'b1;
        MemtoRegE = 1'b1; WA3E = 4'd7; RA1D = 4'd7; RA2D = 4'd0;
        repeat (4) @(posedge clk);
        #1;
        check("stall_cnt_4", StallCount, 4);
        check("flush_cnt_4", FlushCount, 4);
        check("stall_cnt_4_small", StallCount_s, 4);

        @(negedge clk);
        MemtoRegE = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_stall", StallCount, 0);
        check("async_rst_flush", FlushCount, 0);

        @(negedge clk);
        rst_n = 1'b1;
        BranchTakenE = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("branch_flush_cnt", FlushCount, 3);
        check("branch_stall_cnt", StallCount, 0);

        @(negedge clk);
        BranchTakenE = 1'b0;
        MemtoRegE = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("stall_cnt_20", StallCount, 20);
        check("flush_cnt_23", FlushCount, 23);
        check("sat_stall_small", StallCount_s, 15);
        check("sat_flush_small", FlushCount_s, 15);

        @(negedge clk);
        MemtoRegE = 1'b0;
        #1;
        check("sat_hold_small", StallCount_s, 15);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
